// File: rtl/vram_pkg.sv
// Shared types and default sizes for the video RAM arbiter.
package vram_pkg;

    localparam int ADDR_W_DEF    = 16;
    localparam int DATA_W_DEF    = 8;
    localparam int MEM_DEPTH_DEF = 40000;

    typedef enum logic [1:0] {
        SLOT_NONE,
        SLOT_DISP,
        SLOT_HOST_RD,
        SLOT_HOST_WR
    } slot_t;

    // One issued RAM slot as it travels toward its response cycle.
    typedef struct packed {
        slot_t slot;
        logic  oor;
        logic  miss;
    } slot_info_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Host-side valid/ready port of the video RAM arbiter.
interface vram_arbiter_if
    import vram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              host_valid;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ready;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;

    modport master (
        output host_valid,
        output host_we,
        output host_addr,
        output host_wdata,
        input  host_ready,
        input  host_rvalid,
        input  host_rdata
    );

    modport slave (
        input  host_valid,
        input  host_we,
        input  host_addr,
        input  host_wdata,
        output host_ready,
        output host_rvalid,
        output host_rdata
    );

endinterface

// File: rtl/vram_slot_pipe.sv
// Shift pipe carrying each issued slot until its RAM data returns.
module vram_slot_pipe
    import vram_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  slot_info_t in_info,
    output slot_info_t out_info
);

    slot_info_t pipe_q [DEPTH];
    slot_info_t pipe_d [DEPTH];

    always_comb begin
        pipe_d[0] = in_info;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) pipe_q[i] <= '0;
            else     pipe_q[i] <= pipe_d[i];
        end
    end

    assign out_info = pipe_q[DEPTH-1];

endmodule

// File: rtl/vram_arbiter.sv
// Shares single-port video RAM between the display fetch path
// (priority, read-only) and a host valid/ready port.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int MEM_DEPTH    = MEM_DEPTH_DEF,
    parameter int ADDR_OFFSET  = 2,
    parameter int RAM_LAT      = 1,
    parameter int STARVE_LIMIT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_miss,
    vram_arbiter_if.slave     hif,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
    localparam int PIPE_D = 1 + RAM_LAT;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [WAIT_W-1:0] LIMIT_L = WAIT_W'(STARVE_LIMIT);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic              ram_wren_q, ram_wren_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

    logic              force_slot;
    logic              grant_host;
    logic              grant_disp;
    logic [ADDR_W-1:0] disp_eff;
    logic              disp_oor;
    logic              host_oor;
    logic              disp_hit;
    logic              host_hit;
    logic [DATA_W-1:0] rd_value;
    slot_info_t        slot_in;
    slot_info_t        slot_out;

    // Offset wraps modulo the address space; no carry out.
    assign disp_eff = disp_addr + ADDR_W'(ADDR_OFFSET);
    assign disp_oor = {1'b0, disp_eff} >= DEPTH_L;
    assign host_oor = {1'b0, hif.host_addr} >= DEPTH_L;
    assign force_slot = wait_cnt_q >= LIMIT_L;

    always_comb begin
        grant_host = !rst && hif.host_valid
                     && (!disp_req || force_slot);
        grant_disp = !rst && disp_req && !grant_host;

        slot_in = '0;
        slot_in.miss = grant_host && disp_req;
        unique case (1'b1)
            grant_host && hif.host_we: begin
                slot_in.slot = SLOT_HOST_WR;
                slot_in.oor  = host_oor;
            end
            grant_host && !hif.host_we: begin
                slot_in.slot = SLOT_HOST_RD;
                slot_in.oor  = host_oor;
            end
            grant_disp: begin
                slot_in.slot = SLOT_DISP;
                slot_in.oor  = disp_oor;
            end
            default: ;
        endcase
    end

    always_comb begin
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        ram_wren_d    = 1'b0;
        if (grant_host) begin
            ram_address_d = hif.host_addr;
            ram_data_d    = hif.host_wdata;
            ram_wren_d    = hif.host_we && !host_oor;
        end else if (grant_disp) begin
            ram_address_d = disp_eff;
        end
    end

    always_comb begin
        wait_cnt_d = '0;
        if (hif.host_valid && !grant_host) begin
            wait_cnt_d = force_slot ? wait_cnt_q
                                    : wait_cnt_q + 1'b1;
        end
    end

    vram_slot_pipe #(
        .DEPTH (PIPE_D)
    ) u_slot_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_info  (slot_in),
        .out_info (slot_out)
    );

    // Response side: data is live in the pulse cycle, then held.
    always_comb begin
        disp_hit     = !rst && slot_out.slot == SLOT_DISP;
        host_hit     = !rst && slot_out.slot == SLOT_HOST_RD;
        rd_value     = slot_out.oor ? '0 : ram_q;
        disp_data_d  = disp_hit ? rd_value : disp_data_q;
        host_rdata_d = host_hit ? rd_value : host_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q    <= '0;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            ram_wren_q    <= 1'b0;
            disp_data_q   <= '0;
            host_rdata_q  <= '0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            ram_wren_q    <= ram_wren_d;
            disp_data_q   <= disp_data_d;
            host_rdata_q  <= host_rdata_d;
        end
    end

    assign hif.host_ready  = grant_host;
    assign hif.host_rvalid = host_hit;
    assign hif.host_rdata  = host_rdata_d;
    assign disp_valid      = disp_hit;
    assign disp_miss       = !rst && slot_out.miss;
    assign disp_data       = disp_data_d;
    assign ram_address     = ram_address_q;
    assign ram_data        = ram_data_q;
    assign ram_wren        = ram_wren_q;

endmodule
